// File: rtl/cbus_flat_arbiter_pkg.sv
// Shared cbus types, burst encodings, arbiter FSM states and the round-robin pick helper.
package cbus_flat_arbiter_pkg;

  localparam int unsigned CBUS_MAX_CH = 8;

  localparam logic [1:0] CBUS_BURST_FIXED = 2'b00;
  localparam logic [1:0] CBUS_BURST_INCR  = 2'b01;
  localparam logic [1:0] CBUS_BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strobe;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [2:0]  size;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] rdata;
  } cbus_resp_t;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valids at or after ptr, wrapping within num_ch channels.
  function automatic rr_pick_t rr_pick(input logic [7:0] valids, input logic [2:0] ptr,
                                       input int unsigned num_ch);
    rr_pick_t    res;
    logic [31:0] k;
    res = '0;
    for (int unsigned i = 0; i < CBUS_MAX_CH; i++) begin
      if (i < num_ch) begin
        k = (32'(ptr) + i) % num_ch;
        if (!res.found && valids[k[2:0]]) begin
          res.found = 1'b1;
          res.idx   = k[2:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cbus_flat_arbiter_if.sv
// Flat memory-bus port: arbiter drives the request side, memory drives the response side.
interface cbus_flat_arbiter_if;
  logic        valid;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic [7:0]  wstrobe;
  logic [1:0]  burst;
  logic [7:0]  len;
  logic [2:0]  size;
  logic        ready;
  logic        last;

  modport master (
    output valid, addr, wdata, wstrobe, burst, len, size,
    input  rdata, ready, last
  );

  modport slave (
    input  valid, addr, wdata, wstrobe, burst, len, size,
    output rdata, ready, last
  );
endinterface

// File: rtl/cbus_rr_picker.sv
// Combinational round-robin priority encoder over NUM_CH request bits.
module cbus_rr_picker
  import cbus_flat_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] valids,
  input  logic [CH_W-1:0]   ptr,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  logic [7:0] valids_ext;
  logic [2:0] ptr_ext;
  rr_pick_t   pick;

  always_comb begin
    valids_ext               = '0;
    valids_ext[NUM_CH-1:0]   = valids;
    ptr_ext                  = '0;
    ptr_ext[CH_W-1:0]        = ptr;
    pick                     = rr_pick(valids_ext, ptr_ext, NUM_CH);
    found                    = pick.found;
    idx                      = pick.idx[CH_W-1:0];
  end

endmodule

// File: rtl/cbus_flat_arbiter.sv
// Round-robin arbiter of NUM_CH cbus masters onto one flat bus, grant held per transaction.
// Optional protocol checker enabled by defining CBUS_ARB_PROTOCOL_CHECK_EN.
module cbus_flat_arbiter
  import cbus_flat_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned CHECK_MAX_LEN = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  cbus_req_t [NUM_CH-1:0]  ireqs,
  output cbus_resp_t [NUM_CH-1:0] iresps,
  cbus_flat_arbiter_if.master     bus,
  output logic [CH_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    proto_err
);

  arb_state_t        state_q, state_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [NUM_CH-1:0] req_valids;
  logic              pick_found;
  logic [CH_W-1:0]   pick_idx;
  cbus_req_t         cur;

  always_comb begin
    for (int k = 0; k < int'(NUM_CH); k++) begin
      req_valids[k] = ireqs[k].valid;
    end
  end

  cbus_rr_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .valids (req_valids),
    .ptr    (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign cur = ireqs[sel_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d    = ARB_BUSY;
          sel_d      = pick_idx;
          len_d      = ireqs[pick_idx].len;
          beat_cnt_d = '0;
        end
      end
      ARB_BUSY: begin
        if (bus.ready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        if (bus.ready && bus.last) begin
          state_d  = ARB_IDLE;
          // Wraps to 0 past the top channel; with one channel this is always 0.
          rr_ptr_d = (sel_q == CH_W'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.valid   = 1'b0;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.wstrobe = '0;
    bus.burst   = '0;
    bus.len     = '0;
    bus.size    = '0;
    iresps      = '0;
    grant_id    = '0;
    busy        = 1'b0;
    if (state_q == ARB_BUSY) begin
      bus.valid           = cur.valid;
      bus.addr            = cur.addr;
      bus.wdata           = cur.wdata;
      bus.wstrobe         = cur.strobe & {8{cur.is_write}};
      bus.burst           = cur.burst;
      bus.len             = cur.len;
      bus.size            = cur.size;
      iresps[sel_q].ready = bus.ready;
      iresps[sel_q].last  = bus.last;
      iresps[sel_q].rdata = bus.rdata;
      grant_id            = sel_q;
      busy                = 1'b1;
    end
  end

`ifdef CBUS_ARB_PROTOCOL_CHECK_EN
  cbus_req_t snap_q;
  logic      proto_err_q;
  logic      in_busy;
  logic      err_last_early, err_last_missing, err_field, err_len;

  always_comb begin
    in_busy          = (state_q == ARB_BUSY);
    err_last_early   = in_busy && bus.ready && bus.last && (beat_cnt_q != len_q);
    err_last_missing = in_busy && bus.ready && !bus.last && (beat_cnt_q == len_q);
    err_field        = in_busy &&
        ({cur.addr, cur.is_write, cur.len, cur.size, cur.burst} !=
         {snap_q.addr, snap_q.is_write, snap_q.len, snap_q.size, snap_q.burst});
    err_len          = in_busy && (32'(len_q) > CHECK_MAX_LEN);
  end

  // Snapshot of the granted request, used to catch mid-transaction field changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (state_q == ARB_IDLE && pick_found) begin
        snap_q <= ireqs[pick_idx];
      end
      if (err_last_early || err_last_missing || err_field || err_len) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign proto_err = proto_err_q;

  a_last_early : assert property (@(posedge clk) disable iff (!reset) !err_last_early)
    else $error("cbus arb: last at beat %0d, len %0d", beat_cnt_q, len_q);
  a_last_missing : assert property (@(posedge clk) disable iff (!reset) !err_last_missing)
    else $error("cbus arb: final beat %0d without last", beat_cnt_q);
  a_field : assert property (@(posedge clk) disable iff (!reset) !err_field)
    else $error("cbus arb: request fields changed during transaction on ch %0d", sel_q);
  a_len : assert property (@(posedge clk) disable iff (!reset) !err_len)
    else $error("cbus arb: len %0d above limit", len_q);
`else
  assign proto_err = 1'b0;
`endif

endmodule
